// File: rtl/fsk_pkg.sv
// Shared definitions for the 1000 Hz / 1500 Hz FSK link: window size, thresholds,
// sample type, carrier states and the modulator's sine tables (32 samples per symbol).
package fsk_pkg;
    localparam int AMOSTRAS_POR_SIMBOLO = 32;
    localparam int MEIO_ESCALA          = 128;
    localparam int HISTERESE            = 16;
    localparam int LIMIAR_TRANSICOES    = 3;
    localparam int LIMIAR_AMPLITUDE     = 64;
    localparam int JANELAS_AQUISICAO    = 2;
    localparam int IDX_W                = $clog2(AMOSTRAS_POR_SIMBOLO);
    localparam int BOAS_W               = $clog2(JANELAS_AQUISICAO + 1);

    typedef enum logic {SEM_PORTADORA = 1'b0, COM_PORTADORA = 1'b1} estado_portadora_t;
    typedef logic [7:0] amostra_t;

    // 128 + round(127*sin(2*pi*f*k/32000)), k = 0..31, phase 0
    localparam amostra_t TABELA_1000HZ [AMOSTRAS_POR_SIMBOLO] = '{
        8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
        8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
        8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
        8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103
    };
    localparam amostra_t TABELA_1500HZ [AMOSTRAS_POR_SIMBOLO] = '{
        8'd128, 8'd165, 8'd199, 8'd226, 8'd245, 8'd254, 8'd253, 8'd240,
        8'd218, 8'd188, 8'd153, 8'd116, 8'd79,  8'd47,  8'd22,  8'd6,
        8'd1,   8'd6,   8'd22,  8'd47,  8'd79,  8'd116, 8'd153, 8'd188,
        8'd218, 8'd240, 8'd253, 8'd254, 8'd245, 8'd226, 8'd199, 8'd165
    };

    // |a - 128| in 8 bits; a = 0 yields 128
    function automatic amostra_t desvio(input amostra_t a);
        return (a >= 8'(MEIO_ESCALA)) ? a - 8'(MEIO_ESCALA) : 8'(MEIO_ESCALA) - a;
    endfunction
endpackage

// File: rtl/detector_cruzamento.sv
// Hysteresis comparator around mid-scale: holds the sign of the signal and flags,
// combinationally, the enabled sample that flips it.
module detector_cruzamento
    import fsk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] amostra,
    input  logic       habilita,
    output logic       sinal,
    output logic       cruzamento
);
    logic sinal_novo;

    // Inside the dead band the previous sign is kept, so noise near 128 never counts
    always_comb begin
        sinal_novo = sinal;
        if (amostra >= 8'(MEIO_ESCALA + HISTERESE))
            sinal_novo = 1'b1;
        else if (amostra <= 8'(MEIO_ESCALA - HISTERESE))
            sinal_novo = 1'b0;
    end

    assign cruzamento = habilita && (sinal_novo != sinal);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sinal <= 1'b0;
        else if (habilita)
            sinal <= sinal_novo;
    end
endmodule

// File: rtl/demodulador_fsk.sv
// FSK demodulator: counts hysteresis crossings and peak per 32-sample window and
// emits one bit per window once the carrier-detect FSM has acquired.
module demodulador_fsk
    import fsk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] amostra,
    input  logic       amostra_valida,
    input  logic       alinhar,
    output logic       bit_rx,
    output logic       bit_valido,
    output logic       portadora,
    output logic [2:0] transicoes
);
    localparam logic [IDX_W-1:0]  ULTIMO   = IDX_W'(AMOSTRAS_POR_SIMBOLO - 1);
    localparam logic [BOAS_W-1:0] BOAS_FIM = BOAS_W'(JANELAS_AQUISICAO - 1);

    logic [IDX_W-1:0]  indice;
    logic [2:0]        contagem;
    logic [7:0]        pico;
    logic [BOAS_W-1:0] janelas_boas;
    estado_portadora_t estado;

    logic       amostra_ok;
    logic       sinal;
    logic       cruzamento;
    logic       fecha;
    logic       boa;
    logic [2:0] contagem_final;
    logic [7:0] pico_final;
    logic [7:0] desvio_atual;

    // A sample presented together with alinhar is discarded entirely
    assign amostra_ok = amostra_valida && !alinhar;

    detector_cruzamento u_detector (
        .clk        (clk),
        .reset      (reset),
        .amostra    (amostra),
        .habilita   (amostra_ok),
        .sinal      (sinal),
        .cruzamento (cruzamento)
    );

    // Totals including the current sample, so the closing sample is counted
    assign desvio_atual   = desvio(amostra);
    assign contagem_final = (cruzamento && contagem != 3'd7) ? contagem + 3'd1 : contagem;
    assign pico_final     = (desvio_atual > pico) ? desvio_atual : pico;
    assign fecha          = amostra_ok && (indice == ULTIMO);
    assign boa            = pico_final >= 8'(LIMIAR_AMPLITUDE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            indice       <= '0;
            contagem     <= '0;
            pico         <= '0;
            janelas_boas <= '0;
            estado       <= SEM_PORTADORA;
            bit_rx       <= 1'b0;
            bit_valido   <= 1'b0;
            portadora    <= 1'b0;
            transicoes   <= '0;
        end else begin
            bit_valido <= 1'b0;
            if (alinhar) begin
                indice   <= '0;
                contagem <= '0;
                pico     <= '0;
            end else if (amostra_valida) begin
                indice <= indice + 1'b1;
                if (fecha) begin
                    contagem   <= '0;
                    pico       <= '0;
                    transicoes <= contagem_final;
                    if (!boa) begin
                        estado       <= SEM_PORTADORA;
                        portadora    <= 1'b0;
                        janelas_boas <= '0;
                    end else if (estado == SEM_PORTADORA) begin
                        // The acquiring window itself never produces a bit
                        if (janelas_boas == BOAS_FIM) begin
                            estado       <= COM_PORTADORA;
                            portadora    <= 1'b1;
                            janelas_boas <= '0;
                        end else begin
                            janelas_boas <= janelas_boas + 1'b1;
                        end
                    end else begin
                        bit_rx     <= (contagem_final >= 3'(LIMIAR_TRANSICOES));
                        bit_valido <= 1'b1;
                    end
                end else begin
                    contagem <= contagem_final;
                    pico     <= pico_final;
                end
            end
        end
    end
endmodule

// File: tb/tb_demodulador_fsk.sv
// Bench for demodulador_fsk: stimulus from the shared sine tables, a sample-level
// reference model pushes expected window results that are popped at each close.
module tb_demodulador_fsk;
    import fsk_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] amostra;
    logic       amostra_valida;
    logic       alinhar;
    logic       bit_rx;
    logic       bit_valido;
    logic       portadora;
    logic [2:0] transicoes;

    demodulador_fsk dut (
        .clk            (clk),
        .reset          (reset),
        .amostra        (amostra),
        .amostra_valida (amostra_valida),
        .alinhar        (alinhar),
        .bit_rx         (bit_rx),
        .bit_valido     (bit_valido),
        .portadora      (portadora),
        .transicoes     (transicoes)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_erros  = 0;

    // {pulse, bit_rx, portadora, transicoes}
    logic [5:0] exp_q[$];

    int m_sinal, m_cont, m_pico, m_idx, m_boas, m_port, m_bit;
    int exp_pulsos = 0;
    int pulsos_vistos = 0;
    int corrida = 0;
    int corrida_max = 0;

    task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic modelo_reset();
        m_sinal = 0; m_cont = 0; m_pico = 0; m_idx = 0;
        m_boas = 0; m_port = 0; m_bit = 0;
    endtask

    task automatic modelo(input amostra_t a, output bit fecha);
        int novo, d, pulso;
        novo = m_sinal;
        if (a >= 144) novo = 1;
        else if (a <= 112) novo = 0;
        if (novo != m_sinal && m_cont < 7) m_cont++;
        m_sinal = novo;
        d = (a >= 128) ? a - 128 : 128 - a;
        if (d > m_pico) m_pico = d;
        fecha = (m_idx == 31);
        m_idx = (m_idx + 1) % 32;
        if (fecha) begin
            pulso = 0;
            if (m_pico < 64) begin
                m_port = 0; m_boas = 0;
            end else if (m_port == 1) begin
                m_bit = (m_cont >= 3) ? 1 : 0;
                pulso = 1;
                exp_pulsos++;
            end else if (m_boas + 1 >= 2) begin
                m_port = 1; m_boas = 0;
            end else begin
                m_boas++;
            end
            exp_q.push_back({pulso[0], m_bit[0], m_port[0], m_cont[2:0]});
            m_cont = 0; m_pico = 0;
        end
    endtask

    task automatic conferir_fecho();
        logic [5:0] e;
        if (exp_q.size() == 0) begin
            checar("fila_vazia", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            checar("bit_valido", bit_valido, e[5]);
            checar("bit_rx", bit_rx, e[4]);
            checar("portadora", portadora, e[3]);
            checar("transicoes", transicoes, e[2:0]);
        end
    endtask

    function automatic amostra_t amostra_de(input int modo, input bit inv, input int k);
        amostra_t a;
        case (modo)
            1:       a = TABELA_1000HZ[k];
            2:       a = TABELA_1500HZ[k];
            default: a = 8'd128;
        endcase
        if (inv) a = 8'(9'd256 - {1'b0, a});
        return a;
    endfunction

    task automatic enviar(input amostra_t a, input int ociosos);
        bit fecha;
        for (int i = 0; i < ociosos; i++) begin
            @(negedge clk);
            amostra_valida = 1'b0;
            amostra = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        amostra = a;
        amostra_valida = 1'b1;
        modelo(a, fecha);
        @(posedge clk);
        #1;
        amostra_valida = 1'b0;
        if (fecha) conferir_fecho();
    endtask

    task automatic janela(input int modo, input bit inv, input int ociosos);
        for (int k = 0; k < 32; k++) enviar(amostra_de(modo, inv, k), ociosos);
    endtask

    always @(negedge clk) begin
        if (bit_valido) begin
            pulsos_vistos++;
            corrida++;
            if (corrida > corrida_max) corrida_max = corrida;
        end else begin
            corrida = 0;
        end
    end

    initial begin
        reset = 1'b0;
        amostra = 8'd128;
        amostra_valida = 1'b0;
        alinhar = 1'b0;
        modelo_reset();
        repeat (3) @(negedge clk);
        checar("rst_bit_rx", bit_rx, 1'b0);
        checar("rst_bit_valido", bit_valido, 1'b0);
        checar("rst_portadora", portadora, 1'b0);
        checar("rst_transicoes", transicoes, 3'd0);
        reset = 1'b1;

        // Silent line: mid-scale only, never acquires
        for (int w = 0; w < 4; w++) janela(0, 1'b0, 0);
        // Acquisition on 1000 Hz, then two bit-0 windows
        for (int w = 0; w < 4; w++) janela(1, 1'b0, 0);
        // 1500 Hz, inverted 1000 Hz, inverted 1500 Hz
        janela(2, 1'b0, 0);
        janela(1, 1'b1, 0);
        janela(2, 1'b1, 0);
        // Carrier loss, then re-acquisition
        janela(0, 1'b0, 0);
        janela(1, 1'b0, 0);
        janela(1, 1'b0, 0);
        // Sparse valid samples: one every 4th cycle
        janela(2, 1'b0, 3);
        janela(2, 1'b1, 3);

        // Realign at index 10: that sample is dropped, window restarts
        for (int k = 0; k < 10; k++) enviar(amostra_de(2, 1'b0, k), 0);
        @(negedge clk);
        amostra = amostra_de(2, 1'b0, 10);
        amostra_valida = 1'b1;
        alinhar = 1'b1;
        m_idx = 0; m_cont = 0; m_pico = 0;
        @(posedge clk);
        #1;
        amostra_valida = 1'b0;
        alinhar = 1'b0;
        checar("alinhar_portadora", portadora, m_port[0]);
        checar("alinhar_transicoes", transicoes, 32'(exp_last_trans()));
        janela(2, 1'b1, 0);

        // Asynchronous reset in the middle of a window
        for (int k = 0; k < 5; k++) enviar(amostra_de(1, 1'b0, k), 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        modelo_reset();
        #1;
        checar("arst_bit_rx", bit_rx, 1'b0);
        checar("arst_bit_valido", bit_valido, 1'b0);
        checar("arst_portadora", portadora, 1'b0);
        checar("arst_transicoes", transicoes, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        janela(1, 1'b0, 0);

        repeat (3) @(negedge clk);
        checar("fila_restante", exp_q.size(), 32'd0);
        checar("pulsos", pulsos_vistos, exp_pulsos);
        checar("largura_pulso", corrida_max, 32'd1);
        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

    // Last closed-window count the model expects to be still displayed
    int ultimo_trans = 0;
    always @(exp_q.size()) begin
        if (exp_q.size() > 0) ultimo_trans = int'(exp_q[exp_q.size() - 1][2:0]);
    end
    function automatic int exp_last_trans();
        return ultimo_trans;
    endfunction
endmodule

// File: doc/demodulador_fsk.md
Name: demodulador_fsk

Overview:
- Receive-side counterpart of the 1000 Hz / 1500 Hz FSK modulator. Consumes the 8-bit offset-binary sine sample stream (mid-scale 128) and recovers one bit per 32-sample symbol window.
- Detection method: count mid-scale crossings (with hysteresis) per window. 1000 Hz gives 2 crossings (bit 0); 1500 Hz gives 3 crossings (bit 1).
- A carrier-detect FSM gates bit output. Sits between the ADC/loopback sample path and the bit sink.

Parameters:
- AMOSTRAS_POR_SIMBOLO, 32: valid samples per symbol window (power of 2).
- HISTERESE, 16: half-width of the dead band around 128.
- LIMIAR_TRANSICOES, 3: crossing count at or above which bit = 1.
- LIMIAR_AMPLITUDE, 64: minimum peak |amostra-128| for a window to count as carrier present.
- JANELAS_AQUISICAO, 2: consecutive good windows required to declare carrier.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- amostra  in  8  offset-binary sample
- amostra_valida  in  1  qualifies amostra; all counters advance only on valid samples
- alinhar  in  1  restart window: the next valid sample becomes index 0
- bit_rx  out  1  recovered bit, held until the next bit_valido
- bit_valido  out  1  one-cycle pulse when bit_rx is updated
- portadora  out  1  carrier-detect state (1 = COM_PORTADORA)
- transicoes  out  3  crossing count of the last closed window, saturating at 7

Behaviour:
- Reset (reset=0, async): bit_rx=0, bit_valido=0, portadora=0, transicoes=0, window index=0, sign register=0 (low), peak=0, good-window count=0, FSM=SEM_PORTADORA.
- Sign register (hysteresis):
  - set to 1 when amostra >= 128+HISTERESE; cleared when amostra <= 128-HISTERESE; otherwise held.
  - Every change on a valid sample increments the window crossing counter (3 bits, saturating at 7).
  - Sign persists across window boundaries.
- Peak: max of |amostra-128| over the window, computed in 8 bits (amostra=0 gives 128).
- Window: index counts valid samples 0..AMOSTRAS_POR_SIMBOLO-1 and wraps to 0.
  - On the valid sample with index = last, the window closes. That sample's crossing and peak are included.
- Window close (registered; outputs visible the cycle after the last valid sample's clock edge):
  - transicoes <= final count.
  - good = (peak >= LIMIAR_AMPLITUDE).
  - Crossing counter and peak clear for the next window.
- FSM:
  - SEM_PORTADORA: on a good close, increment the good-window count. Reaching JANELAS_AQUISICAO → COM_PORTADORA, portadora=1. This window emits no bit. A bad close clears the count.
  - COM_PORTADORA: on a good close, bit_rx <= (count >= LIMIAR_TRANSICOES) and bit_valido pulses for 1 cycle. A bad close → SEM_PORTADORA, portadora=0, count cleared, no bit_valido.
- alinhar=1 (takes priority over amostra_valida in the same cycle):
  - sample discarded; index, crossing counter and peak cleared.
  - FSM state, good-window count, sign register and outputs unchanged.
- Gaps in amostra_valida: all state is held. bit_valido never lasts more than one cycle.
- Ideal modulator stream, sign persistence: 1000 Hz (either phase) yields exactly 2 crossings per window; 1500 Hz (either phase) yields exactly 3.
- Mid-operation reset: immediate return to reset values. A partial window is lost.

Decomposition:
- Package fsk_pkg:
  - AMOSTRAS_POR_SIMBOLO, MEIO_ESCALA=128.
  - typedef enum estado_portadora_t {SEM_PORTADORA, COM_PORTADORA}.
  - typedef logic [7:0] amostra_t.
  - The modulator's sine tables, so the bench and modulator share one source.
- Sub-module detector_cruzamento: hysteresis comparator, sign register and crossing pulse.
- Top level holds the window counter, peak, FSM and outputs.

Test Plan:
- Reset hold, then release with amostra=128 continuous → all outputs 0, portadora stays 0 for 4 windows, no bit_valido.
- 4 windows of 1000 Hz table (phase 0), one sample/cycle:
  - portadora=1 after window 1 closes.
  - bit_valido after windows 2 and 3 with bit_rx=0, transicoes=2.
- After acquisition, 1500 Hz phase-0 window then 1500 Hz phase-1 window → two pulses, bit_rx=1, transicoes=3 each. Then one inverted 1000 Hz window → bit_rx=0, transicoes=2.
- While COM_PORTADORA, one window of amostra=128 (peak 0):
  - no bit_valido, portadora=0 the cycle after close.
  - Next good windows re-acquire after 2 closes.
- amostra_valida asserted every 4th cycle, 1500 Hz stream → same bits. bit_valido exactly 1 cycle, the cycle after the 32nd valid sample.
- alinhar pulsed at window index 10 (same cycle as a valid sample), then reset asserted mid-window:
  - after alinhar: index restarts, that sample is ignored, the next close occurs 32 valid samples later, FSM unchanged.
  - after reset: all outputs 0 asynchronously.
